// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam seg_t SEG_DASH  = 7'h3F;
  localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low segment decoder.
// Nibbles A-F are not valid BCD and show a dash.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  // Table lookup; anything outside 0-9 falls through to the dash.
  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0: seg = SEG_DIGIT[0];
      4'd1: seg = SEG_DIGIT[1];
      4'd2: seg = SEG_DIGIT[2];
      4'd3: seg = SEG_DIGIT[3];
      4'd4: seg = SEG_DIGIT[4];
      4'd5: seg = SEG_DIGIT[5];
      4'd6: seg = SEG_DIGIT[6];
      4'd7: seg = SEG_DIGIT[7];
      4'd8: seg = SEG_DIGIT[8];
      4'd9: seg = SEG_DIGIT[9];
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// A snapshot of the packed BCD word is taken once per frame (and right after
// reset) so the counter can advance mid-scan without tearing the frame.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks zero digits above the
// most significant nonzero digit (digit 0 is always shown).
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int                    SCAN_DIV = 1000,
  parameter logic [NUM_DIGITS-1:0] DP_MASK  = 8'b0101_0100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           data,
  output logic [NUM_DIGITS-1:0] an,
  output seg_t                  seg,
  output logic                  dp
);

  localparam int            PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [2:0]    digit_idx;
  logic [31:0]   snapshot;
  logic          load_pending;
  logic          tick;
  logic          load;
  logic [3:0]    nibble;
  seg_t          digit_seg;
  seg_t          seg_next;

  assign tick   = (prescaler == PRE_MAX);
  // Reload at the frame boundary, or immediately after reset release.
  assign load   = load_pending | (tick & (digit_idx == 3'd7));
  assign nibble = snapshot[{digit_idx, 2'b00} +: 4];

  bcd_to_seg u_dec (
    .nibble (nibble),
    .seg    (digit_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_run;

  // A digit is blank when it and every digit above it are zero.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (snapshot[i*4 +: 4] == 4'd0);
      blank[i] = zero_run;
    end
  end

  assign seg_next = blank[digit_idx] ? SEG_BLANK : digit_seg;
`else
  assign seg_next = digit_seg;
`endif

  // Slot prescaler: one tick every SCAN_DIV clocks.
  always_ff @(posedge clk) begin
    if (reset)     prescaler <= '0;
    else if (tick) prescaler <= '0;
    else           prescaler <= prescaler + 1'b1;
  end

  // Digit pointer advances once per slot and wraps 7 -> 0 naturally.
  always_ff @(posedge clk) begin
    if (reset)     digit_idx <= 3'd0;
    else if (tick) digit_idx <= digit_idx + 3'd1;
  end

  // Frame snapshot of the BCD word.
  always_ff @(posedge clk) begin
    if (reset) begin
      snapshot     <= 32'h0;
      load_pending <= 1'b1;
    end else if (load) begin
      snapshot     <= data;
      load_pending <= 1'b0;
    end
  end

  // Registered display outputs, one clock behind digit_idx.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'b1 << digit_idx);
      seg <= seg_next;
      dp  <= ~DP_MASK[digit_idx];
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed testbench for seven_seg_scanner with SCAN_DIV = 4 (32-clk frame).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data = 32'h0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks   = 0;
  int failures = 0;

  logic [7:0] an_tbl   [0:7] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] seg_9876 [0:7] = '{7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [7:0] dp_tbl = 8'hAB;

  always #5 clk = ~clk;

  seven_seg_scanner #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset for n cycles with the given data, release, stop just after E0.
  task automatic restart(input logic [31:0] d, input int n);
    data  = d;
    reset = 1'b1;
    repeat (n) next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset();
    data  = 32'h1234_5678;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checks++;
      if (an !== 8'hFF) begin failures++; $display("FAIL reset_an cyc=%0d got=%h exp=ff", i, an); end
      checks++;
      if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg cyc=%0d got=%h exp=7f", i, seg); end
      checks++;
      if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp cyc=%0d got=%b exp=1", i, dp); end
    end
    reset = 1'b0;
    next_cycle();
    checks++;
    if (an !== 8'hFE) begin failures++; $display("FAIL release_an_e0 got=%h exp=fe", an); end
    next_cycle();
    checks++;
    if (an !== 8'hFE) begin failures++; $display("FAIL release_an_e1 got=%h exp=fe", an); end
    checks++;
    if (seg !== 7'h00) begin failures++; $display("FAIL release_seg_e1 got=%h exp=00", seg); end
    checks++;
    if (dp !== 1'b1) begin failures++; $display("FAIL release_dp_e1 got=%b exp=1", dp); end
    repeat (3) next_cycle();
    checks++;
    if (an !== 8'hFD) begin failures++; $display("FAIL slot1_an got=%h exp=fd", an); end
    checks++;
    if (seg !== 7'h78) begin failures++; $display("FAIL slot1_seg got=%h exp=78", seg); end
    checks++;
    if (dp !== 1'b1) begin failures++; $display("FAIL slot1_dp got=%b exp=1", dp); end
  endtask

  task automatic test_full_frame();
    restart(32'h9876_5432, 2);
    for (int m = 1; m <= 32; m++) begin
      int k;
      next_cycle();
      k = (m / 4) % 8;
      checks++;
      if (an !== an_tbl[k]) begin failures++; $display("FAIL frame_an m=%0d got=%h exp=%h", m, an, an_tbl[k]); end
      checks++;
      if (seg !== seg_9876[k]) begin failures++; $display("FAIL frame_seg m=%0d got=%h exp=%h", m, seg, seg_9876[k]); end
      checks++;
      if (dp !== dp_tbl[k]) begin failures++; $display("FAIL frame_dp m=%0d got=%b exp=%b", m, dp, dp_tbl[k]); end
    end
  endtask

  task automatic test_snapshot_hold();
    restart(32'h0000_0000, 2);
    for (int m = 1; m <= 63; m++) begin
      int k;
      logic [6:0] exp_seg;
      next_cycle();
      k = (m / 4) % 8;
      if (m >= 32) exp_seg = 7'h79;
`ifdef LEADING_ZERO_BLANK_EN
      else if (k != 0) exp_seg = 7'h7F;
`endif
      else exp_seg = 7'h40;
      checks++;
      if (seg !== exp_seg) begin failures++; $display("FAIL hold_seg m=%0d got=%h exp=%h", m, seg, exp_seg); end
      if (m == 12) data = 32'h1111_1111;
    end
  endtask

  task automatic test_invalid();
    restart(32'hABCD_EF00, 2);
    for (int m = 1; m <= 31; m++) begin
      int k;
      logic [6:0] exp_seg;
      next_cycle();
      k = m / 4;
      exp_seg = (k < 2) ? 7'h40 : 7'h3F;
      if (m % 4 == 1) begin
        checks++;
        if (seg !== exp_seg) begin failures++; $display("FAIL invalid_seg digit=%0d got=%h exp=%h", k, seg, exp_seg); end
      end
    end
  endtask

  task automatic test_reset_mid();
    restart(32'h1234_5678, 2);
    repeat (21) next_cycle();
    checks++;
    if (an !== 8'hDF) begin failures++; $display("FAIL mid_pre_an got=%h exp=df", an); end
    reset = 1'b1;
    data  = 32'h0000_0042;
    next_cycle();
    checks++;
    if (an !== 8'hFF) begin failures++; $display("FAIL mid_reset_an got=%h exp=ff", an); end
    checks++;
    if (seg !== 7'h7F) begin failures++; $display("FAIL mid_reset_seg got=%h exp=7f", seg); end
    checks++;
    if (dp !== 1'b1) begin failures++; $display("FAIL mid_reset_dp got=%b exp=1", dp); end
    next_cycle();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    checks++;
    if (an !== 8'hFE) begin failures++; $display("FAIL mid_restart_an got=%h exp=fe", an); end
    checks++;
    if (seg !== 7'h24) begin failures++; $display("FAIL mid_restart_seg got=%h exp=24", seg); end
    repeat (3) next_cycle();
    checks++;
    if (an !== 8'hFD) begin failures++; $display("FAIL mid_slot1_an got=%h exp=fd", an); end
    checks++;
    if (seg !== 7'h19) begin failures++; $display("FAIL mid_slot1_seg got=%h exp=19", seg); end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_blank();
    restart(32'h0000_0000, 2);
    for (int m = 1; m <= 31; m++) begin
      int k;
      logic [6:0] exp_seg;
      next_cycle();
      k = m / 4;
      exp_seg = (k == 0) ? 7'h40 : 7'h7F;
      if (m % 4 == 1) begin
        checks++;
        if (seg !== exp_seg) begin failures++; $display("FAIL blank0_seg digit=%0d got=%h exp=%h", k, seg, exp_seg); end
        checks++;
        if (an !== an_tbl[k]) begin failures++; $display("FAIL blank0_an digit=%0d got=%h exp=%h", k, an, an_tbl[k]); end
      end
    end
    restart(32'h0010_0000, 2);
    for (int m = 1; m <= 31; m++) begin
      int k;
      logic [6:0] exp_seg;
      next_cycle();
      k = m / 4;
      if (k >= 6)      exp_seg = 7'h7F;
      else if (k == 5) exp_seg = 7'h79;
      else             exp_seg = 7'h40;
      if (m % 4 == 1) begin
        checks++;
        if (seg !== exp_seg) begin failures++; $display("FAIL blank1_seg digit=%0d got=%h exp=%h", k, seg, exp_seg); end
        checks++;
        if (dp !== dp_tbl[k]) begin failures++; $display("FAIL blank1_dp digit=%0d got=%b exp=%b", k, dp, dp_tbl[k]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_snapshot_hold();
    test_invalid();
    test_reset_mid();
`ifdef LEADING_ZERO_BLANK_EN
    test_blank();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
